// File: rtl/fpu_issue_scheduler.sv
// Round-robin issue of two requesters onto pipelined FP add/mul units. Writeback
// slots are reserved at grant time so at most one result returns per cycle.
module fpu_issue_scheduler #(
  parameter int ADD_LAT = 4,
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        add_valid_in,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic        add_valid_out,
  input  logic [31:0] add_result,
  output logic        mul_valid_in,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_valid_out,
  input  logic [31:0] mul_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [3:0]  inflight,
  output logic        err_illegal,
  output logic        err_protocol
);

  localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int DEPTH   = MAX_LAT + 1;

  localparam logic [1:0] OP_ILL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef struct packed {
    logic valid;
    logic id;
    logic is_mul;
  } slot_t;

  // slot_reg[k] describes the completion expected k cycles from now
  slot_t slot_reg   [DEPTH];
  slot_t slot_next  [DEPTH];
  slot_t slot_shift [DEPTH];
  logic  rr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH - 1; gi++) begin : g_shift
      assign slot_shift[gi] = slot_reg[gi + 1];
    end
  endgenerate
  assign slot_shift[DEPTH-1] = '0;

  // A new op completes LAT+1 cycles after its grant cycle
  logic add_free, mul_free;
  always_comb begin
    add_free = 1'b1;
    mul_free = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == ADD_LAT + 1 && slot_reg[k].valid) add_free = 1'b0;
      if (k == MUL_LAT + 1 && slot_reg[k].valid) mul_free = 1'b0;
    end
  end

  function automatic logic op_eligible(input logic v, input logic [1:0] op,
                                       input logic af, input logic mf);
    logic e;
    case (op)
      OP_MUL:  e = mf;
      OP_ILL:  e = 1'b1;
      default: e = af;
    endcase
    return v & e;
  endfunction

  logic        elig0, elig1, grant_valid, grant_id;
  logic [1:0]  sel_op;
  logic [31:0] sel_a, sel_b;
  logic        issue_add, issue_mul, take_ill;

  assign elig0       = op_eligible(req0_valid, req0_op, add_free, mul_free);
  assign elig1       = op_eligible(req1_valid, req1_op, add_free, mul_free);
  assign grant_valid = elig0 | elig1;
  assign grant_id    = (elig0 & elig1) ? rr_reg : elig1;
  assign sel_op      = grant_id ? req1_op : req0_op;
  assign sel_a       = grant_id ? req1_a  : req0_a;
  assign sel_b       = grant_id ? req1_b  : req0_b;

  assign req0_ready = grant_valid & ~grant_id & ~rst;
  assign req1_ready = grant_valid &  grant_id & ~rst;

  assign issue_add = grant_valid & ((sel_op == OP_ADD) | (sel_op == OP_SUB));
  assign issue_mul = grant_valid & (sel_op == OP_MUL);
  assign take_ill  = grant_valid & (sel_op == OP_ILL);

  always_comb begin
    for (int k = 0; k < DEPTH; k++) slot_next[k] = slot_shift[k];
    if (issue_add) slot_next[ADD_LAT] = {1'b1, grant_id, 1'b0};
    if (issue_mul) slot_next[MUL_LAT] = {1'b1, grant_id, 1'b1};
  end

  slot_t head;
  logic  exp_add, exp_mul, proto_bad;
  assign head      = slot_reg[0];
  assign exp_add   = head.valid & ~head.is_mul;
  assign exp_mul   = head.valid &  head.is_mul;
  // Missing completion and unreserved completion are both a mismatch
  assign proto_bad = (exp_add ^ add_valid_out) | (exp_mul ^ mul_valid_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) slot_reg[k] <= '0;
      rr_reg       <= 1'b0;
      add_valid_in <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
      mul_valid_in <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      inflight     <= '0;
      err_illegal  <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) slot_reg[k] <= slot_next[k];
      if (grant_valid) rr_reg <= ~grant_id;

      add_valid_in <= issue_add;
      mul_valid_in <= issue_mul;
      if (issue_add) begin
        add_a <= sel_a;
        add_b <= (sel_op == OP_SUB) ? {~sel_b[31], sel_b[30:0]} : sel_b;
      end
      if (issue_mul) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
      end

      rsp_valid <= head.valid;
      if (head.valid) begin
        rsp_id   <= head.id;
        rsp_data <= head.is_mul ? mul_result : add_result;
      end

      case ({issue_add | issue_mul, rsp_valid})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase

      err_illegal  <= err_illegal | take_ill;
      err_protocol <= err_protocol | proto_bad;
    end
  end

endmodule

// File: doc/fpu_issue_scheduler.md
Name: fpu_issue_scheduler

Overview:
- Dual-requester issue scheduler in front of the pipelined FP adder and FP multiplier.
- Arbitrates round-robin between two requesters and drives the units' valid_in and operands. Subtract is mapped onto the adder by flipping the sign of operand b.
- Reserves writeback slots at issue time so at most one result completes per cycle. Returns each result tagged with the requester id.
- Replaces the single-op IDLE/WAIT sequencing with back-to-back pipelined issue.

Parameters:
- ADD_LAT, 4, adder latency: valid_in high in cycle T gives valid_out/result in cycle T+ADD_LAT (≥1).
- MUL_LAT, 3, multiplier latency, same definition (≥1).

Ports:
- Interface: one clock; reset is asynchronous and active-high.
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- req0_valid  input  1  requester 0 has an op.
- req0_op  input  2  01 add, 10 mul, 11 sub, 00 illegal.
- req0_a  input  32  IEEE-754 single operand a.
- req0_b  input  32  operand b.
- req0_ready  output  1  req0 accepted this cycle (combinational grant).
- req1_valid / req1_op / req1_a / req1_b / req1_ready: same as req0, for requester 1.
- add_valid_in  output  1  adder issue strobe.
- add_a  output  32  adder operand a.
- add_b  output  32  adder operand b, sign already flipped for sub.
- add_valid_out  input  1  adder completion.
- add_result  input  32  adder result.
- mul_valid_in  output  1  multiplier issue strobe.
- mul_a  output  32  multiplier operand a.
- mul_b  output  32  multiplier operand b.
- mul_valid_out  input  1  multiplier completion.
- mul_result  input  32  multiplier result.
- rsp_valid  output  1  response strobe. No backpressure.
- rsp_id  output  1  requester that issued the op.
- rsp_data  output  32  result.
- inflight  output  4  count of issued, not-yet-responded ops.
- err_illegal  output  1  sticky flag: an op 00 was consumed.
- err_protocol  output  1  sticky flag: a unit's valid_out disagreed with the reservation.

Behaviour:
- Reset: all outputs 0, reservation table empty, rr pointer = 0. Reset mid-operation discards all in-flight ops and emits no responses for them. The units share this reset.
- Eligibility: requester i is eligible when valid=1 and one of:
  - op is 01/11 and the adder writeback slot is free;
  - op is 10 and the multiplier writeback slot is free;
  - op is 00 (always eligible).
- Grant: at most one grant per cycle.
  - If both requesters are eligible, grant rr; then rr ← ~granted id.
  - If one is eligible, grant it; rr ← ~granted id.
  - req_ready is high only for the granted requester. An ineligible requester never blocks the other.
- Accept at cycle T (valid & ready):
  - Operands and op are registered.
  - In cycle T+1 exactly one of add_valid_in/mul_valid_in is high for one cycle, with operands. For sub, add_b = {~b[31], b[30:0]}.
  - Operand outputs hold their last value when not issuing.
- Op 00: consumed at T, no unit issue, no response, err_illegal ← 1.
- Writeback slots:
  - Completion cycle C = T+1+LAT.
  - Reservation shift table of depth max(ADD_LAT,MUL_LAT)+1 entries {valid, id, unit}, advancing every cycle.
  - A grant is allowed only if no earlier accepted op has the same C.
  - Same-unit back-to-back issue never collides. Cross-unit collisions are stalled.
- Response:
  - In cycle C the expected unit's valid_out is sampled.
  - rsp_valid=1 in cycle C+1 with rsp_data = the registered unit result and rsp_id = the reserved id.
  - Total accept-to-response latency is LAT+2. Responses come out in completion order, not issue order.
- err_protocol ← 1 when either of these happens in a cycle:
  - a reserved unit's valid_out is low;
  - any unit's valid_out is high with no matching reservation.
  - The response is still emitted with whatever result is present.
- inflight counter:
  - +1 on accept of a non-00 op, −1 on rsp_valid; both in the same cycle leaves it unchanged.
  - Never exceeds max LAT+2. 4 bits are sufficient for the defaults.
- Simultaneous grant and completion in the same cycle is legal.

Test Plan:
- Add issue and response: req0 op=01, a=3F800000, b=40000000, accepted T → add_valid_in at T+1 with those operands; stub adder returns 40400000 at T+5 → rsp_valid at T+6, rsp_id=0, rsp_data=40400000, inflight 1→0.
- Subtract mapping: req1 op=11, b=40000000 → add_b=C0000000, mul_valid_in stays 0.
- Round-robin: both requesters valid with add ops for 4 cycles after reset → grants alternate 0,1,0,1; responses at T+6..T+9 carry ids 0,1,0,1.
- Writeback collision: add accepted at T (C=T+5), then mul requested at T+1 (C=T+5) → req_ready=0 at T+1, mul accepted at T+2; rsp at T+6 (add) and T+7 (mul).
- Illegal op: req0 op=00 → ready=1 same cycle, no unit valid_in, err_illegal=1, inflight unchanged, no rsp. Stub asserting add_valid_out with no reservation → err_protocol=1.
- Reset mid-operation: 3 ops in flight, rst pulsed → all outputs 0 immediately; no rsp_valid afterwards; next accept behaves as after power-up with rr=0.
